// File: rtl/bitstream_decoder.sv
// Stochastic bitstream decoder: counts the ones in a WINDOW-bit window after
// start and presents the count on a valid/ready handshake.
module bitstream_decoder #(
  parameter int WINDOW      = 1024,
  parameter int COUNT_WIDTH = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   clear,
  input  logic                   x,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COUNT_WIDTH-1:0] result
);

  localparam int SCW = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [SCW-1:0] LAST = SCW'(WINDOW - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SCW-1:0]         r_samp;
  logic [COUNT_WIDTH-1:0] r_ones;
  logic [COUNT_WIDTH-1:0] r_result;
  logic                   w_last;
  logic                   w_restart;
  logic [COUNT_WIDTH-1:0] w_ones_nxt;

  assign w_last     = (r_state == ACCUM) && (r_samp == LAST);
  assign w_ones_nxt = r_ones + COUNT_WIDTH'(x);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_restart   = 1'b0;
    case (r_state)
      IDLE: if (start) begin
        w_state_nxt = ACCUM;
        w_restart   = 1'b1;
      end
      ACCUM: if (w_last) w_state_nxt = DONE;
      DONE: if (out_ready) begin
        w_state_nxt = start ? ACCUM : IDLE;
        w_restart   = start;
      end
      default: w_state_nxt = IDLE;
    endcase
    // clear overrides any transition, including a handshake restart
    if (clear) begin
      w_state_nxt = IDLE;
      w_restart   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_samp   <= '0;
      r_ones   <= '0;
      r_result <= '0;
    end else if (w_restart) begin
      r_samp <= '0;
      r_ones <= '0;
    end else if (r_state == ACCUM && !clear) begin
      r_ones <= w_ones_nxt;
      // sample counter stops at the final index instead of wrapping
      if (w_last) r_result <= w_ones_nxt;
      else        r_samp   <= r_samp + 1'b1;
    end
  end

  assign busy      = (r_state == ACCUM);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;

endmodule

// File: tb/tb_bitstream_decoder.sv
// Directed bench for bitstream_decoder: an 8-bit window instance and a
// 1024-bit window instance driven with hand-computed stream patterns.
module tb_bitstream_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // small window instance
  logic        a_rst, a_start, a_clear, a_x, a_ready;
  logic        a_busy, a_valid;
  logic [3:0]  a_result;

  bitstream_decoder #(.WINDOW(8), .COUNT_WIDTH(4)) u_dut8 (
    .clk(clk), .rst(a_rst), .start(a_start), .clear(a_clear), .x(a_x),
    .busy(a_busy), .out_valid(a_valid), .out_ready(a_ready), .result(a_result)
  );

  // full window instance
  logic        k_rst, k_start, k_clear, k_x, k_ready;
  logic        k_busy, k_valid;
  logic [10:0] k_result;

  bitstream_decoder #(.WINDOW(1024), .COUNT_WIDTH(11)) u_dut1k (
    .clk(clk), .rst(k_rst), .start(k_start), .clear(k_clear), .x(k_x),
    .busy(k_busy), .out_valid(k_valid), .out_ready(k_ready), .result(k_result)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic pat(input int mode, input int i);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      default: return (i % 2 == 0);
    endcase
  endfunction

  // start on the 1k instance, feed n samples of a pattern; pulse_at
  // re-asserts start on that sample index to prove it is ignored
  task automatic k_feed(input int mode, input int n, input int pulse_at);
    k_start = 1'b1;
    step();
    k_start = 1'b0;
    chk("k_busy_after_start", k_busy, 1);
    for (int i = 0; i < n; i++) begin
      k_x     = pat(mode, i);
      k_start = (i == pulse_at);
      if (i == 1023) chk("k_valid_before_last", k_valid, 0);
      step();
    end
    k_start = 1'b0;
  endtask

  task automatic k_handshake();
    k_ready = 1'b1;
    step();
    k_ready = 1'b0;
    chk("k_idle_after_hs", k_valid, 0);
  endtask

  logic [7:0] bits8;
  logic [10:0] held;

  initial begin
    bits8 = 8'b1000_1101; // bit i is sample i: 1,0,1,1,0,0,0,1
    {a_rst, a_start, a_clear, a_x, a_ready} = 5'b10000;
    {k_rst, k_start, k_clear, k_x, k_ready} = 5'b10000;
    step();
    chk("a_reset_busy",   a_busy, 0);
    chk("a_reset_valid",  a_valid, 0);
    chk("a_reset_result", a_result, 0);
    chk("k_reset_result", k_result, 0);
    a_rst = 1'b0;
    k_rst = 1'b0;
    step();

    // window of 8: x during the start cycle is ignored
    a_start = 1'b1;
    a_x     = 1'b1;
    step();
    a_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a_x = bits8[i];
      chk("a_busy_accum", a_busy, 1);
      chk("a_valid_early", a_valid, 0);
      step();
    end
    chk("a_valid_t9", a_valid, 1);
    chk("a_result", a_result, 4);
    chk("a_busy_done", a_busy, 0);
    for (int i = 0; i < 3; i++) begin
      a_x = ~a_x;
      step();
    end
    chk("a_result_held", a_result, 4);
    chk("a_valid_held", a_valid, 1);
    a_ready = 1'b1;
    step();
    a_ready = 1'b0;
    chk("a_valid_after_hs", a_valid, 0);
    chk("a_result_idle", a_result, 4);

    // 1k window: zeros, ones, alternating
    k_feed(0, 1024, -1);
    chk("k_zeros_valid", k_valid, 1);
    chk("k_zeros", k_result, 0);
    k_handshake();
    k_feed(1, 1024, -1);
    chk("k_ones_valid", k_valid, 1);
    chk("k_ones", k_result, 1024);
    k_handshake();
    k_feed(2, 1024, -1);
    chk("k_alt", k_result, 512);

    // back-pressure with a toggling stream
    for (int i = 0; i < 20; i++) begin
      k_x = ~k_x;
      step();
      chk("k_bp_valid", k_valid, 1);
      chk("k_bp_result", k_result, 512);
    end
    k_ready = 1'b1;
    k_start = 1'b1;
    step();
    k_ready = 1'b0;
    k_start = 1'b0;
    chk("k_b2b_busy", k_busy, 1);
    chk("k_b2b_valid", k_valid, 0);
    for (int i = 0; i < 1024; i++) begin
      k_x = 1'b1;
      step();
    end
    chk("k_b2b_valid_end", k_valid, 1);
    chk("k_b2b_ones", k_result, 1024);
    k_handshake();

    // asynchronous reset mid-window
    k_feed(1, 500, -1);
    #2 k_rst = 1'b1;
    #1;
    chk("k_rst_busy", k_busy, 0);
    chk("k_rst_valid", k_valid, 0);
    chk("k_rst_result", k_result, 0);
    step();
    k_rst = 1'b0;
    step();
    k_feed(2, 1024, -1);
    chk("k_after_rst", k_result, 512);
    k_handshake();

    // clear mid-window: no result, previous result retained
    k_feed(1, 100, -1);
    k_clear = 1'b1;
    step();
    k_clear = 1'b0;
    chk("k_clr_busy", k_busy, 0);
    chk("k_clr_valid", k_valid, 0);
    chk("k_clr_result", k_result, 512);
    held = k_result;
    for (int i = 0; i < 1030; i++) step();
    chk("k_clr_stays_idle", k_valid, 0);
    chk("k_clr_result_kept", k_result, held);

    // start pulse inside the window is dropped
    k_feed(1, 1024, 300);
    chk("k_pulse_valid", k_valid, 1);
    chk("k_pulse_ones", k_result, 1024);
    k_handshake();
    step();
    chk("k_pulse_not_queued", k_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bitstream_decoder.md
Name: bitstream_decoder

Overview:
- Converts a unipolar stochastic bitstream (one bit per clock, as produced by the constant and sigmoid stream generators) back to a binary magnitude by counting ones over a fixed window of WINDOW cycles.
- Sits at the network output boundary and in self-check benches, where it turns stream results into integers for comparison or readout.
- Operates on start; the result is delivered on a valid/ready handshake.

Parameters:
- WINDOW, 1024, number of stream bits accumulated per conversion (≥2).
- COUNT_WIDTH, 11, width of count and result. Must satisfy 2^COUNT_WIDTH > WINDOW so a full all-ones window (count = WINDOW) fits.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a conversion; honoured only in IDLE, or in DONE on the handshake cycle.
- clear  input  1  synchronous abort; returns to IDLE and discards any partial count.
- x  input  1  stochastic bitstream input.
- busy  output  1  high while in ACCUM.
- out_valid  output  1  result available (DONE state).
- out_ready  input  1  consumer accepts result.
- result  output  COUNT_WIDTH  number of ones seen in the window, 0..WINDOW.

Behaviour:
- Reset (async, rst=1):
  - State becomes IDLE.
  - Sample counter = 0, ones counter = 0.
  - result = 0, busy = 0, out_valid = 0.
  - Applies immediately, including mid-ACCUM or mid-DONE; the partial result is lost.
- States:
  - IDLE: busy = 0, out_valid = 0. When start = 1, go to ACCUM next cycle with both counters cleared.
  - ACCUM: busy = 1.
    - Each cycle, x is sampled: the ones counter increments if x = 1, and the sample counter increments.
    - The first sample is taken in the first cycle spent in ACCUM, i.e. the cycle after start was seen. The x value during the start cycle is ignored.
    - When the sample counter reaches WINDOW-1 and that final bit has been sampled, the next state is DONE. On that transition, result is loaded with the final count, including the last bit.
    - start is ignored while in ACCUM.
  - DONE: out_valid = 1, busy = 0, and result is held stable.
    - On out_valid & out_ready: if start = 1 in the same cycle, go directly to ACCUM with counters cleared (back-to-back conversion). Otherwise go to IDLE.
    - If out_ready = 0, stay in DONE indefinitely. x is ignored.
- clear: highest priority after reset. Any state → IDLE next cycle, out_valid drops, result retains its last value.
- Latency: start seen at cycle t → out_valid first high at cycle t+WINDOW+1.
- Counters:
  - Ones counter is COUNT_WIDTH bits and never wraps: its maximum is WINDOW.
  - Sample counter is ceil(log2(WINDOW)) bits and terminates at WINDOW-1; it does not rely on power-of-two wrap.
- result stays unchanged outside the DONE load, so it reads the previous conversion while IDLE or ACCUM.
- Simultaneous events: rst > clear > handshake/start. start during ACCUM is dropped, not queued.

Test Plan:
- WINDOW=8. Reset, start, then x = 1,0,1,1,0,0,0,1 → out_valid high 9 cycles after start; result = 4, held until out_ready.
- WINDOW=1024:
  - all-zeros stream → result = 0.
  - all-ones stream → result = 1024, with no overflow into 0.
  - alternating 1,0 stream → result = 512.
- Back-pressure:
  - Hold out_ready = 0 for 20 cycles in DONE while toggling x → result and out_valid stable.
  - Then raise out_ready and start together → ACCUM next cycle; second conversion of all-ones returns WINDOW.
- Asynchronous rst asserted mid-ACCUM (sample 500 of 1024) → busy, out_valid and result = 0 immediately. A new start then returns the correct count for a fresh window.
- clear pulsed mid-ACCUM → IDLE next cycle, with no out_valid.
- start pulsed during ACCUM → ignored; the window still ends exactly WINDOW samples after the original start.
